mips_bus_ram: RTL and testbench

- Word-wide RAM responder for the CPU's read/write/waitrequest memory bus. It is the slave end of the interface the CPU drives as master.
- Provides a configurable number of wait states and byte-lane writes, and maps a window starting at the MIPS reset vector.
- Used as instruction/data memory in CPU testbenches and in the top-level system wrapper.

---
 rtl/mips_bus_ram.sv | 158 +++++++++++++++
 tb/tb_mips_bus_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_ram.sv
// rtl/mips_bus_ram.sv - word-wide RAM slave for the MIPS read/write/waitrequest bus
// Wait-stated, byte-lane writes, window based at BASE_ADDR; one transfer in flight.
module mips_bus_ram #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [31:0] xfer_count
);

  localparam int          IDXW      = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN      = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] readdata_q, readdata_d;
  logic        err_q, err_d;
  logic [31:0] xfer_q, xfer_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0]     acc_addr, acc_wdata, offset, mem_rdata;
  logic [3:0]      acc_be;
  logic            acc_rd, acc_wr, in_range, do_access, mem_we;
  logic [IDXW-1:0] index;

  // In IDLE the access (zero-wait case) uses the bus directly; later it uses the latch.
  always_comb begin
    acc_addr  = (state_q == S_IDLE) ? address    : addr_q;
    acc_wdata = (state_q == S_IDLE) ? writedata  : wdata_q;
    acc_be    = (state_q == S_IDLE) ? byteenable : be_q;
    acc_rd    = (state_q == S_IDLE) ? read       : rd_q;
    acc_wr    = (state_q == S_IDLE) ? write      : wr_q;
    offset    = acc_addr - BASE_ADDR;
    in_range  = {1'b0, offset} < SPAN;
    index     = offset[IDXW+1:2];
    mem_rdata = mem_q[index];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    readdata_d = readdata_q;
    err_d      = err_q;
    xfer_d     = xfer_q;
    do_access  = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          addr_d  = address;
          wdata_d = writedata;
          be_d    = byteenable;
          rd_d    = read;
          wr_d    = write;
          if (read && write) err_d = 1'b1;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = S_ACK;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!read && !write) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            do_access = 1'b1;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        xfer_d  = xfer_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
      if (acc_rd && acc_wr) begin
        readdata_d = 32'h0;
      end else begin
        if (!in_range || (acc_addr[1:0] != 2'b00)) err_d = 1'b1;
        if (acc_rd) readdata_d = in_range ? mem_rdata : 32'h0;
        else        mem_we     = in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'h0;
      err_q      <= 1'b0;
      xfer_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
      xfer_q     <= xfer_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
  end

  // Array contents survive reset; reset only blocks a write on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[index][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign waitrequest = reset || (state_q != S_ACK);
  assign readdata    = readdata_q;
  assign err         = err_q;
  assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_mips_bus_ram.sv
// tb/tb_mips_bus_ram.sv - scoreboard bench for mips_bus_ram
// Instance a has two wait states, instance b has none; both share clock and reset.
module tb_mips_bus_ram;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_a = '0, wd_a = '0, addr_b = '0, wd_b = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [3:0]  be_a = '0, be_b = '0;
  logic        wait_a, wait_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b, cnt_a, cnt_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] model_a [int];
  logic [31:0] model_b [int];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_bus_ram #(.WAIT_CYCLES(2), .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .address(addr_a), .read(rd_a), .write(wr_a),
    .writedata(wd_a), .byteenable(be_a), .waitrequest(wait_a), .readdata(rdata_a),
    .err(err_a), .xfer_count(cnt_a)
  );

  mips_bus_ram #(.WAIT_CYCLES(0), .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .address(addr_b), .read(rd_b), .write(wr_b),
    .writedata(wd_b), .byteenable(be_b), .waitrequest(wait_b), .readdata(rdata_b),
    .err(err_b), .xfer_count(cnt_b)
  );

  function automatic logic [31:0] mdl_read(input bit sel, input logic [31:0] a);
    logic [31:0] off;
    int idx;
    off = a - BASE;
    if (off >= 32'(WORDS * 4)) return 32'h0;
    idx = int'(off >> 2);
    if (sel) return model_b.exists(idx) ? model_b[idx] : 32'h0;
    return model_a.exists(idx) ? model_a[idx] : 32'h0;
  endfunction

  function automatic void mdl_write(input bit sel, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] be);
    logic [31:0] off, w;
    int idx;
    off = a - BASE;
    if (off >= 32'(WORDS * 4)) return;
    idx = int'(off >> 2);
    w = mdl_read(sel, BASE + (off & 32'hFFFF_FFFC));
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    if (sel) model_b[idx] = w;
    else     model_a[idx] = w;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that ends the ACK cycle.
  task automatic xfer(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rdata, output int lat);
    bit done;
    if (sel) begin rd_b = rd; wr_b = wr; addr_b = a; wd_b = d; be_b = be; end
    else     begin rd_a = rd; wr_a = wr; addr_a = a; wd_a = d; be_a = be; end
    if (wr && !rd) mdl_write(sel, a, d, be);
    lat = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ((sel ? wait_b : wait_a) == 1'b0) begin
        done = 1'b1;
      end else begin
        lat++;
        if (lat > 40) begin
          n_cmp++; n_bad++;
          $display("FAIL xfer_timeout: waitrequest still %b after %0d cycles, required 0", 1'b1, lat);
          done = 1'b1;
        end
      end
    end
    rdata = sel ? rdata_b : rdata_a;
    @(posedge clk); #1;
    if (sel) begin rd_b = 1'b0; wr_b = 1'b0; end
    else     begin rd_a = 1'b0; wr_a = 1'b0; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (wait_a !== 1'b1) begin n_bad++; $display("FAIL rst_wait_a: got %b need 1", wait_a); end
    n_cmp++; if (wait_b !== 1'b1) begin n_bad++; $display("FAIL rst_wait_b: got %b need 1", wait_b); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (wait_a !== 1'b1) begin n_bad++; $display("FAIL idle_wait_a: got %b need 1", wait_a); end
    n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_rdata_a: got %h need 0", rdata_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rst_err_a: got %b need 0", err_a); end
    n_cmp++; if (cnt_a !== 32'h0) begin n_bad++; $display("FAIL rst_cnt_a: got %0d need 0", cnt_a); end
    n_cmp++; if (wait_b !== 1'b1) begin n_bad++; $display("FAIL idle_wait_b: got %b need 1", wait_b); end
    n_cmp++; if (cnt_b !== 32'h0) begin n_bad++; $display("FAIL rst_cnt_b: got %0d need 0", cnt_b); end
  endtask

  task automatic test_read_wait();
    logic [31:0] r, e;
    int lat;
    xfer(1'b0, 1'b0, 1'b1, BASE, 32'h24020005, 4'hF, r, lat);
    pulse_reset();
    exp_q.push_back(mdl_read(1'b0, BASE));
    xfer(1'b0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL read_word0: got %h need %h", r, e); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL read_latency: got %0d need 3", lat); end
    n_cmp++; if (cnt_a !== 32'd1) begin n_bad++; $display("FAIL read_count: got %0d need 1", cnt_a); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r, e;
    int lat;
    xfer(1'b0, 1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'b1111, r, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency: got %0d need 3", lat); end
    xfer(1'b0, 1'b0, 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, r, lat);
    exp_q.push_back(mdl_read(1'b0, BASE + 32'h10));
    xfer(1'b0, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL byte_lanes: got %h need %h", r, e); end
    n_cmp++; if (r !== 32'hDE22BE44) begin n_bad++; $display("FAIL byte_lanes_const: got %h need DE22BE44", r); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL lanes_err: got %b need 0", err_a); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] r, e;
    int lat, lat0, t0;
    for (int i = 0; i < 3; i++)
      xfer(1'b1, 1'b0, 1'b1, BASE + 32'(4 * i), 32'hA5000000 + 32'(i * 32'h1111), 4'hF, r, lat);
    xfer(1'b1, 1'b0, 1'b1, BASE + 32'h4, 32'hFFFFFFFF, 4'b0000, r, lat);
    pulse_reset();
    t0 = cyc;
    lat0 = -1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mdl_read(1'b1, BASE + 32'(4 * i)));
      xfer(1'b1, 1'b1, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, r, lat);
      if (i == 0) lat0 = lat;
      e = exp_q.pop_front();
      n_cmp++; if (r !== e) begin n_bad++; $display("FAIL zw_read%0d: got %h need %h", i, r, e); end
    end
    n_cmp++; if (lat0 !== 1) begin n_bad++; $display("FAIL zw_latency: got %0d need 1", lat0); end
    n_cmp++; if (cyc - t0 !== 6) begin n_bad++; $display("FAIL zw_cycles: got %0d need 6", cyc - t0); end
    n_cmp++; if (cnt_b !== 32'd3) begin n_bad++; $display("FAIL zw_count: got %0d need 3", cnt_b); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] r, e;
    int lat;
    exp_q.push_back(mdl_read(1'b0, 32'h0));
    xfer(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL oor_rdata: got %h need %h", r, e); end
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b need 1", err_a); end
    xfer(1'b0, 1'b0, 1'b1, BASE + 32'h2, 32'h0BADF00D, 4'hF, r, lat);
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL unaligned_err: got %b need 1", err_a); end
    exp_q.push_back(mdl_read(1'b0, BASE));
    xfer(1'b0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL unaligned_word: got %h need %h", r, e); end
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b need 1", err_a); end
    pulse_reset();
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b need 0", err_a); end
  endtask

  task automatic test_both_high();
    logic [31:0] r, e;
    int lat;
    xfer(1'b0, 1'b1, 1'b1, BASE + 32'h10, 32'h0, 4'hF, r, lat);
    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL both_rdata: got %h need 0", r); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL both_latency: got %0d need 3", lat); end
    n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL both_err: got %b need 1", err_a); end
    n_cmp++; if (cnt_a !== 32'd1) begin n_bad++; $display("FAIL both_count: got %0d need 1", cnt_a); end
    exp_q.push_back(mdl_read(1'b0, BASE + 32'h10));
    xfer(1'b0, 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL both_no_write: got %h need %h", r, e); end
    pulse_reset();
  endtask

  task automatic test_reset_in_busy();
    logic [31:0] r, e;
    int lat;
    xfer(1'b0, 1'b0, 1'b1, BASE + 32'h20, 32'hCAFEF00D, 4'hF, r, lat);
    rd_a = 1'b0; wr_a = 1'b1; addr_a = BASE + 32'h20; wd_a = 32'h87654321; be_a = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (wait_a !== 1'b1) begin n_bad++; $display("FAIL busy_rst_wait: got %b need 1", wait_a); end
    @(posedge clk); #1;
    reset = 1'b0;
    wr_a = 1'b0;
    #1;
    n_cmp++; if (cnt_a !== 32'd0) begin n_bad++; $display("FAIL busy_rst_count: got %0d need 0", cnt_a); end
    n_cmp++; if (wait_a !== 1'b1) begin n_bad++; $display("FAIL busy_rst_idle: got %b need 1", wait_a); end
    exp_q.push_back(mdl_read(1'b0, BASE + 32'h20));
    xfer(1'b0, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL busy_rst_word: got %h need %h", r, e); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL busy_rst_fresh_lat: got %0d need 3", lat); end
  endtask

  task automatic test_abort();
    logic [31:0] r, e;
    int lat;
    xfer(1'b0, 1'b0, 1'b1, BASE + 32'h14, 32'h55AA55AA, 4'hF, r, lat);
    rd_a = 1'b0; wr_a = 1'b1; addr_a = BASE + 32'h14; wd_a = 32'h12345678; be_a = 4'hF;
    @(posedge clk); #1;
    wr_a = 1'b0;
    @(negedge clk);
    n_cmp++; if (wait_a !== 1'b1) begin n_bad++; $display("FAIL abort_wait: got %b need 1", wait_a); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (cnt_a !== 32'd2) begin n_bad++; $display("FAIL abort_count: got %0d need 2", cnt_a); end
    exp_q.push_back(mdl_read(1'b0, BASE + 32'h14));
    xfer(1'b0, 1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'h0, r, lat);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL abort_word: got %h need %h", r, e); end
    n_cmp++; if (cnt_a !== 32'd3) begin n_bad++; $display("FAIL abort_after_count: got %0d need 3", cnt_a); end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_byte_lanes();
    test_zero_wait();
    test_out_of_range();
    test_both_high();
    test_reset_in_busy();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
